// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    // Loader FSM states; CHECK is only reachable in checksum builds.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage : imem_loader_pkg

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer. Byte 0 of a word lands in [7:0], byte 3 in
// [31:24]. The word register is cleared whenever a word is consumed or a load
// restarts. A word closed early by the last program byte therefore carries zeros
// in its unfilled upper bytes.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              push,
    input  logic              flush,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        byte_idx
);

    // Place each pushed byte at the current index; flush empties the word.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            word     <= '0;
            byte_idx <= 2'd0;
        end else if (push) begin
            word[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx                      <= byte_idx + 2'd1;
        end
    end

endmodule : imem_word_packer

// File: rtl/imem_loader.sv
// Instruction-memory loader. It packs a byte stream into 32-bit words and writes
// them at sequential word addresses starting at 0. The CPU is held in reset while
// a load is in progress.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to enable a trailing XOR
// checksum byte. That byte is compared against all program bytes accepted in the
// load.
//
// Handshake: a byte transfers on any rising edge where byte_valid && byte_ready.
// byte_ready is a pure decode of the state (RECV or CHECK). It never depends on
// byte_valid. A producer may hold byte_valid/byte_in stable until it sees
// byte_ready.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        state_dbg
);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     count_q;
    logic                last_q;
    logic                hold_q;
    logic                done_q;
    logic                err_q;
    logic                push;
    logic                flush;
    logic                fire;
    logic                full;
    logic [WORD_W-1:0]   packed_word;
    logic [1:0]          byte_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q;
`endif

    assign fire = byte_valid && byte_ready;
    assign full = (count_q == DEPTH_C);

    imem_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .byte_in  (byte_in),
        .push     (push),
        .flush    (flush),
        .word     (packed_word),
        .byte_idx (byte_idx)
    );

    // Next-state and per-state strobes; every output defaulted before the case.
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = RECV;
                    flush   = 1'b1;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    push = 1'b1;
                    if (byte_last || (byte_idx == 2'd3)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // A word arriving with memory already full is dropped, not written.
                wr_en = !full;
                flush = 1'b1;
                if (last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load bookkeeping: address/count, last-byte flag, hold/done/error flags, checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= 8'h00;
`endif
        end else begin
            if (state_q == IDLE && load_start) begin
                addr_q  <= '0;
                count_q <= '0;
                last_q  <= 1'b0;
                hold_q  <= 1'b1;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_q   <= 8'h00;
`endif
            end
            if (state_q == RECV && fire) begin
                last_q <= byte_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_q  <= xor_q ^ byte_in;
`endif
            end
            if (state_q == WRITE) begin
                if (full) begin
                    err_q <= 1'b1;
                end else begin
                    addr_q  <= addr_q + ADDR_ONE;
                    count_q <= count_q + COUNT_ONE;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state_q == CHECK && fire && (byte_in != xor_q)) begin
                err_q <= 1'b1;
            end
`endif
            // Release the CPU and flag completion as the FSM enters DONE.
            if (state_d == DONE && state_q != DONE) begin
                done_q <= 1'b1;
                hold_q <= 1'b0;
            end
        end
    end

    assign wr_addr    = addr_q;
    assign wr_data    = packed_word;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign word_count = count_q;
    assign state_dbg  = state_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, single word, partial word, overflow,
// reset mid-load, gapped stream with a stray load_start, and checksum variants.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_last;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;
    logic [2:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    logic [7:0] tb_xor;
    logic [ADDR_W+31:0] act_q[$];
    logic [ADDR_W+31:0] exp_q[$];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // write monitor: record every memory write seen between edges
    always @(negedge clk) begin
        if (wr_en === 1'b1) act_q.push_back({wr_addr, wr_data});
    end

    // ---------------- driver tasks ----------------
    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        tb_xor = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        byte_in    = b;
        byte_last  = last;
        byte_valid = 1'b1;
        n = 0;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL byte_accept: byte_ready got %b required 1 within 20 cycles", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_prog(input logic [7:0] b, input logic last);
        tb_xor = tb_xor ^ b;
        send_byte(b, last);
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_xor, 1'b0);
`endif
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (load_done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: load_done got %b required 1 within 50 cycles", load_done);
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b cnt=%0d required all 0",
                     byte_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, word_count);
        end
        checks++;
        if (state_dbg !== 3'(IDLE)) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", state_dbg, 3'(IDLE));
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore();
        act_q.delete();
        byte_in = 8'hAA; byte_last = 1'b1; byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b required 0", byte_ready);
        end
        byte_valid = 1'b0; byte_last = 1'b0;
        @(negedge clk);
        checks++;
        if (act_q.size() != 0 || word_count !== 7'd0 || state_dbg !== 3'(IDLE)) begin
            errors++;
            $display("FAIL idle_ignore: writes=%0d cnt=%0d state=%0d required 0 0 %0d",
                     act_q.size(), word_count, state_dbg, 3'(IDLE));
        end
    endtask

    task automatic test_single_word();
        act_q.delete();
        start_load();
        checks++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b1 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL start_flags: hold=%b rdy=%b done=%b required 1 1 0", cpu_hold, byte_ready, load_done);
        end
        send_prog(8'h13, 1'b0);
        send_prog(8'h00, 1'b0);
        send_prog(8'h00, 1'b0);
        send_prog(8'h20, 1'b1);
        // the cycle after the completing byte carries the write
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h20000013) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%0d data=%h required 1 0 20000013", wr_en, wr_addr, wr_data);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        finish_load();
`else
        @(negedge clk);
`endif
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 7'd1 || load_err !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b hold=%b cnt=%0d err=%b we=%b required 1 0 1 0 0",
                     load_done, cpu_hold, word_count, load_err, wr_en);
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'(IDLE) || load_done !== 1'b1 || act_q.size() != 1) begin
            errors++;
            $display("FAIL single_idle: state=%0d done=%b writes=%0d required %0d 1 1",
                     state_dbg, load_done, act_q.size(), 3'(IDLE));
        end
    endtask

    task automatic test_partial_word();
        act_q.delete();
        exp_q.delete();
        exp_q.push_back({6'd0, 32'h04030201});
        exp_q.push_back({6'd1, 32'h00000605});
        start_load();
        for (int i = 1; i <= 6; i++) send_prog(8'(i), i == 6);
        finish_load();
        wait_done();
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL partial_count: writes got %0d required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL partial_write%0d: got %h required %h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (word_count !== 7'd2 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL partial_status: cnt=%0d err=%b required 2 0", word_count, load_err);
        end
    endtask

    task automatic test_overflow();
        int bad;
        logic [7:0] b;
        act_q.delete();
        exp_q.delete();
        start_load();
        for (int w = 0; w < 65; w++) begin
            logic [31:0] word;
            for (int k = 0; k < 4; k++) begin
                b = 8'(w * 4 + k) ^ 8'h5A;
                word[k*8 +: 8] = b;
                send_prog(b, (w == 64) && (k == 3));
            end
            if (w < 64) exp_q.push_back({6'(w), word});
        end
        finish_load();
        wait_done();
        checks++;
        if (act_q.size() != 64) begin
            errors++;
            $display("FAIL overflow_writes: got %0d required 64", act_q.size());
        end
        bad = 0;
        for (int i = 0; i < 64 && i < act_q.size(); i++) begin
            if (act_q[i] !== exp_q[i]) begin
                if (bad == 0) $display("FAIL overflow_data%0d: got %h required %h", i, act_q[i], exp_q[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (word_count !== 7'd64 || load_err !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL overflow_status: cnt=%0d err=%b hold=%b required 64 1 0", word_count, load_err, cpu_hold);
        end
    endtask

    task automatic test_reset_mid_load();
        act_q.delete();
        start_load();
        for (int i = 0; i < 10; i++) send_prog(8'hA0 + 8'(i), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, word_count} !== '0
            || state_dbg !== 3'(IDLE)) begin
            errors++;
            $display("FAIL midreset_outputs: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b cnt=%0d st=%0d required all 0",
                     byte_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, word_count, state_dbg);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (act_q.size() != 2) begin
            errors++;
            $display("FAIL midreset_pre_writes: got %0d required 2", act_q.size());
        end
        act_q.delete();
        start_load();
        send_prog(8'h11, 1'b0);
        send_prog(8'h22, 1'b0);
        send_prog(8'h33, 1'b0);
        send_prog(8'h44, 1'b1);
        finish_load();
        wait_done();
        checks++;
        if (act_q.size() != 1 || act_q[0] !== {6'd0, 32'h44332211}) begin
            errors++;
            $display("FAIL midreset_fresh: writes=%0d first=%h required 1 %h",
                     act_q.size(), (act_q.size() > 0) ? act_q[0] : '0, {6'd0, 32'h44332211});
        end
    endtask

    task automatic test_gaps_and_stray_start();
        int gap;
        act_q.delete();
        exp_q.delete();
        exp_q.push_back({6'd0, 32'h33323130});
        exp_q.push_back({6'd1, 32'h37363534});
        exp_q.push_back({6'd2, 32'h00003938});
        start_load();
        for (int i = 0; i < 10; i++) begin
            send_prog(8'h30 + 8'(i), i == 9);
            gap = $urandom_range(0, 3);
            if (i == 5) begin
                load_start = 1'b1;
                @(negedge clk);
                load_start = 1'b0;
            end
            repeat (gap) @(negedge clk);
        end
        finish_load();
        wait_done();
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL gaps_count: writes got %0d required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL gaps_write%0d: got %h required %h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (word_count !== 7'd3 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_status: cnt=%0d err=%b required 3 0", word_count, load_err);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] cs [2];
        logic       exp_err [2];
        cs[0] = 8'h04; exp_err[0] = 1'b0;
        cs[1] = 8'h05; exp_err[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            act_q.delete();
            start_load();
            for (int i = 1; i <= 4; i++) send_prog(8'(i), i == 4);
            send_byte(cs[t], 1'b0);
            wait_done();
            checks++;
            if (load_err !== exp_err[t] || act_q.size() != 1 || act_q[0] !== {6'd0, 32'h04030201}) begin
                errors++;
                $display("FAIL checksum%0d: err=%b writes=%0d required err=%b writes=1 data 04030201",
                         t, load_err, act_q.size(), exp_err[t]);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; load_start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0;
        tb_xor = 8'h00;
        @(negedge clk);
        test_reset();
        test_idle_ignore();
        test_single_word();
        test_partial_word();
        test_overflow();
        test_reset_mid_load();
        test_gaps_and_stray_start();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_imem_loader
